// File: rtl/ysyx_23060240_lsu_axi.sv
// ysyx_23060240_lsu_axi: load/store unit bridging single core memory requests onto an AXI4-Lite master port.
module ysyx_23060240_lsu_axi #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_2,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic [2:0]        memory_rd_ctrl,
  input  logic [1:0]        memory_wr_ctrl,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wr_data,
  output logic              finish_2,
  output logic [31:0]       mem_rd_data,
  output logic              mem_err,
  output logic              busy,
  output logic [ADDR_W-1:0] araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready
);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_e;
  state_e            state_q, state_d;
  logic [2:0]        rd_ctrl_q, rd_ctrl_d;
  logic [1:0]        wr_ctrl_q, wr_ctrl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              err_q, err_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;
  logic              accept, mis_rd, mis_wr, req_err, aw_fin, w_fin, r_take, b_take;
  logic [31:0]       lane, load_val;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rd_ctrl_q <= '0;
      wr_ctrl_q <= '0;
      addr_q    <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_ctrl_q <= rd_ctrl_d;
      wr_ctrl_q <= wr_ctrl_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
  always_comb begin
    mis_rd  = (memory_rd_ctrl[1:0] == 2'b01 && mem_addr[0]) || (memory_rd_ctrl[1:0] == 2'b10 && mem_addr[1:0] != 2'b00);
    mis_wr  = (memory_wr_ctrl == 2'b01 && mem_addr[0]) || (memory_wr_ctrl == 2'b10 && mem_addr[1:0] != 2'b00);
    req_err = (mem_rd_en && mem_wr_en) || (mem_rd_en && mis_rd) || (mem_wr_en && mis_wr);
    aw_fin  = aw_done_q || (awvalid && awready);
    w_fin   = w_done_q || (wvalid && wready);
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_2) state_d = (req_err || !(mem_rd_en || mem_wr_en)) ? DONE : mem_rd_en ? RD_ADDR : WR_REQ;
      RD_ADDR: if (arready) state_d = RD_DATA;
      RD_DATA: if (rvalid) state_d = DONE;
      WR_REQ:  if (aw_fin && w_fin) state_d = WR_RESP;
      WR_RESP: if (bvalid) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  // Valids come only from registered state so they never follow a ready combinationally.
  always_comb begin
    arvalid  = state_q == RD_ADDR;
    rready   = state_q == RD_DATA;
    awvalid  = state_q == WR_REQ && !aw_done_q;
    wvalid   = state_q == WR_REQ && !w_done_q;
    bready   = state_q == WR_RESP;
    finish_2 = state_q == DONE;
    busy     = state_q != IDLE;
    araddr   = {addr_q[ADDR_W-1:2], 2'b00};
    awaddr   = {addr_q[ADDR_W-1:2], 2'b00};
    wdata    = wr_ctrl_q == 2'b00 ? {4{wr_data_q[7:0]}} : wr_ctrl_q == 2'b01 ? {2{wr_data_q[15:0]}} : wr_data_q;
    wstrb    = wr_ctrl_q == 2'b00 ? 4'b0001 << addr_q[1:0] : wr_ctrl_q == 2'b01 ? 4'b0011 << addr_q[1:0] : 4'b1111;
    mem_rd_data = rd_data_q;
    mem_err     = err_q;
  end
  always_comb begin
    accept    = state_q == IDLE && valid_2;
    r_take    = state_q == RD_DATA && rvalid;
    b_take    = state_q == WR_RESP && bvalid;
    lane      = rdata >> {addr_q[1:0], 3'b000};
    load_val  = rd_ctrl_q[1:0] == 2'b00 ? {{24{!rd_ctrl_q[2] && lane[7]}}, lane[7:0]} :
                rd_ctrl_q[1:0] == 2'b01 ? {{16{!rd_ctrl_q[2] && lane[15]}}, lane[15:0]} : rdata;
    rd_ctrl_d = accept ? memory_rd_ctrl : rd_ctrl_q;
    wr_ctrl_d = accept ? memory_wr_ctrl : wr_ctrl_q;
    addr_d    = accept ? mem_addr : addr_q;
    wr_data_d = accept ? mem_wr_data : wr_data_q;
    rd_data_d = r_take ? load_val : rd_data_q;
    err_d     = accept ? req_err : r_take ? rresp != 2'b00 : b_take ? bresp != 2'b00 : err_q;
    aw_done_d = state_q == WR_REQ && aw_fin && !w_fin;
    w_done_d  = state_q == WR_REQ && w_fin && !aw_fin;
  end
endmodule

// File: tb/tb_ysyx_23060240_lsu_axi.sv
// tb_ysyx_23060240_lsu_axi: directed load/store/error/reset vectors against the AXI4-Lite LSU.
module tb_ysyx_23060240_lsu_axi;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid_2 = 1'b0, mem_rd_en = 1'b0, mem_wr_en = 1'b0;
  logic [2:0]  memory_rd_ctrl = '0;
  logic [1:0]  memory_wr_ctrl = '0;
  logic [31:0] mem_addr = '0, mem_wr_data = '0;
  logic        finish_2, mem_err, busy;
  logic [31:0] mem_rd_data;
  logic [31:0] araddr, awaddr, wdata;
  logic        arvalid, rready, awvalid, wvalid, bready;
  logic        arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic [1:0]  rresp = '0, bresp = '0;
  logic [3:0]  wstrb;
  int          n_chk = 0, n_pass = 0;
  int          ar_seen, aw_seen, lat, fin_cnt;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;

  ysyx_23060240_lsu_axi #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .valid_2(valid_2), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .memory_rd_ctrl(memory_rd_ctrl), .memory_wr_ctrl(memory_wr_ctrl), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .finish_2(finish_2), .mem_rd_data(mem_rd_data), .mem_err(mem_err),
    .busy(busy), .araddr(araddr), .arvalid(arvalid), .arready(arready), .rdata(rdata), .rresp(rresp),
    .rvalid(rvalid), .rready(rready), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready), .bresp(bresp), .bvalid(bvalid),
    .bready(bready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Issues one request, tracks bus activity until finish_2, then checks the pulse ended.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] rc, input logic [1:0] wc,
                        input logic [31:0] a, input logic [31:0] d);
    ar_seen = 0; aw_seen = 0; lat = -1;
    cap_araddr = 'x; cap_awaddr = 'x; cap_wdata = 'x; cap_wstrb = 'x;
    @(negedge clk);
    valid_2 = 1'b1; mem_rd_en = rd; mem_wr_en = wr;
    memory_rd_ctrl = rc; memory_wr_ctrl = wc; mem_addr = a; mem_wr_data = d;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      valid_2 = 1'b0;
      if (arvalid) begin ar_seen++; cap_araddr = araddr; end
      if (awvalid) begin aw_seen++; cap_awaddr = awaddr; end
      if (wvalid) begin cap_wdata = wdata; cap_wstrb = wstrb; end
      if (finish_2) begin lat = i; break; end
    end
    @(negedge clk);
    chk("pulse_end", {30'd0, finish_2, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {24'd0, finish_2, busy, arvalid, rready, awvalid, wvalid, bready, mem_err}, 32'd0);
    chk("rst_data", mem_rd_data, 32'd0);
    rst = 1'b1;

    arready = 1'b1; rvalid = 1'b1; rresp = 2'b00;
    rdata = 32'h80AB_CDEF;
    run_op(1'b1, 1'b0, 3'b100, 2'b00, 32'h8000_0003, 32'd0);
    chk("lbu_lat", 32'(lat), 32'd3);
    chk("lbu_araddr", cap_araddr, 32'h8000_0000);
    chk("lbu_ar_cnt", 32'(ar_seen), 32'd1);
    chk("lbu_data", mem_rd_data, 32'h0000_0080);

    rdata = 32'h8001_1234;
    run_op(1'b1, 1'b0, 3'b001, 2'b00, 32'h8000_0002, 32'd0);
    chk("lh_data", mem_rd_data, 32'hFFFF_8001);
    chk("lh_err", {31'd0, mem_err}, 32'd0);

    run_op(1'b1, 1'b0, 3'b101, 2'b00, 32'h8000_0002, 32'd0);
    chk("lhu_data", mem_rd_data, 32'h0000_8001);

    rdata = 32'h0000_8000;
    run_op(1'b1, 1'b0, 3'b000, 2'b00, 32'h8000_0001, 32'd0);
    chk("lb_data", mem_rd_data, 32'hFFFF_FF80);

    run_op(1'b1, 1'b0, 3'b010, 2'b00, 32'h8000_0001, 32'd0);
    chk("lw_mis_lat", 32'(lat), 32'd1);
    chk("lw_mis_err", {31'd0, mem_err}, 32'd1);
    chk("lw_mis_ar", 32'(ar_seen), 32'd0);
    chk("lw_mis_hold", mem_rd_data, 32'hFFFF_FF80);

    // sh with awready arriving two cycles after the write-data handshake
    awready = 1'b0; wready = 1'b1; bvalid = 1'b0; bresp = 2'b00; fin_cnt = 0;
    @(negedge clk);
    valid_2 = 1'b1; mem_rd_en = 1'b0; mem_wr_en = 1'b1; memory_wr_ctrl = 2'b01;
    mem_addr = 32'h8000_0002; mem_wr_data = 32'h1234_5678;
    @(negedge clk);
    valid_2 = 1'b0; fin_cnt += int'(finish_2);
    chk("sh_valids", {30'd0, awvalid, wvalid}, 32'd3);
    chk("sh_wdata", wdata, 32'h5678_5678);
    chk("sh_wstrb", {28'd0, wstrb}, 32'b1100);
    chk("sh_awaddr", awaddr, 32'h8000_0000);
    @(negedge clk);
    fin_cnt += int'(finish_2);
    chk("sh_w_drop", {30'd0, awvalid, wvalid}, 32'd2);
    valid_2 = 1'b1; mem_rd_en = 1'b1; mem_wr_en = 1'b0; mem_addr = 32'h0000_1000; mem_wr_data = 32'hFFFF_FFFF;
    @(negedge clk);
    valid_2 = 1'b0; mem_rd_en = 1'b0; fin_cnt += int'(finish_2);
    chk("sh_aw_hold", {29'd0, awvalid, wvalid, arvalid}, 32'd4);
    chk("sh_latched", wdata, 32'h5678_5678);
    awready = 1'b1;
    @(negedge clk);
    awready = 1'b0; fin_cnt += int'(finish_2);
    chk("sh_bready", {30'd0, awvalid, bready}, 32'd1);
    bvalid = 1'b1;
    @(negedge clk);
    bvalid = 1'b0; fin_cnt += int'(finish_2);
    chk("sh_finish", {31'd0, finish_2}, 32'd1);
    @(negedge clk);
    fin_cnt += int'(finish_2);
    chk("sh_idle", {29'd0, busy, arvalid, mem_err}, 32'd0);
    chk("sh_fin_cnt", 32'(fin_cnt), 32'd1);

    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    run_op(1'b0, 1'b1, 3'b000, 2'b00, 32'h8000_0001, 32'h0000_00A5);
    chk("sb_lat", 32'(lat), 32'd3);
    chk("sb_wdata", cap_wdata, 32'hA5A5_A5A5);
    chk("sb_wstrb", {28'd0, cap_wstrb}, 32'b0010);
    chk("sb_awaddr", cap_awaddr, 32'h8000_0000);

    bresp = 2'b10;
    run_op(1'b0, 1'b1, 3'b000, 2'b10, 32'h8000_0008, 32'hCAFE_F00D);
    chk("sw_lat", 32'(lat), 32'd3);
    chk("sw_wdata", cap_wdata, 32'hCAFE_F00D);
    chk("sw_wstrb", {28'd0, cap_wstrb}, 32'hF);
    chk("sw_berr", {31'd0, mem_err}, 32'd1);

    rdata = 32'h1122_3344; rresp = 2'b00;
    run_op(1'b1, 1'b0, 3'b010, 2'b00, 32'h8000_000C, 32'd0);
    chk("lw_clr_err", {31'd0, mem_err}, 32'd0);
    chk("lw_data", mem_rd_data, 32'h1122_3344);

    run_op(1'b0, 1'b0, 3'b010, 2'b10, 32'h8000_0000, 32'd0);
    chk("noop_lat", 32'(lat), 32'd1);
    chk("noop_bus", 32'(ar_seen + aw_seen), 32'd0);
    chk("noop_err", {31'd0, mem_err}, 32'd0);

    run_op(1'b1, 1'b1, 3'b010, 2'b10, 32'h8000_0000, 32'd0);
    chk("both_lat", 32'(lat), 32'd1);
    chk("both_err", {31'd0, mem_err}, 32'd1);

    run_op(1'b0, 1'b1, 3'b000, 2'b01, 32'h8000_0001, 32'd0);
    chk("sh_mis_err", {31'd0, mem_err}, 32'd1);
    chk("sh_mis_aw", 32'(aw_seen), 32'd0);

    // reset while waiting in RD_DATA
    arready = 1'b1; rvalid = 1'b0; fin_cnt = 0;
    @(negedge clk);
    valid_2 = 1'b1; mem_rd_en = 1'b1; mem_wr_en = 1'b0; memory_rd_ctrl = 3'b010; mem_addr = 32'h8000_0004;
    @(negedge clk);
    valid_2 = 1'b0;
    chk("mid_arvalid", {31'd0, arvalid}, 32'd1);
    @(negedge clk);
    chk("mid_rready", {31'd0, rready}, 32'd1);
    #2 rst = 1'b0;
    #1 chk("mid_rst_ctl", {27'd0, arvalid, rready, busy, finish_2, mem_err}, 32'd0);
    chk("mid_rst_data", mem_rd_data, 32'd0);
    rvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      fin_cnt += int'(finish_2);
    end
    rst = 1'b1;
    @(negedge clk);
    fin_cnt += int'(finish_2);
    chk("mid_no_fin", 32'(fin_cnt), 32'd0);
    rdata = 32'hDEAD_BEEF;
    run_op(1'b1, 1'b0, 3'b010, 2'b00, 32'h8000_0010, 32'd0);
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_data", mem_rd_data, 32'hDEAD_BEEF);
    chk("post_rst_araddr", cap_araddr, 32'h8000_0010);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ysyx_23060240_lsu_axi.md
YSYX_23060240_LSU_AXI -- requirements
Module: ysyx_23060240_lsu_axi

Interface
REQ-001 Parameter: ADDR_W, 32, bus address width; data width fixed at 32.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 valid_2  in  1  one-cycle start pulse from core; request sampled only in IDLE.
REQ-005 mem_rd_en / mem_wr_en  in  1 each  load / store request qualifiers.
REQ-006 memory_rd_ctrl  in  3  funct3 load type: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
REQ-007 memory_wr_ctrl  in  2  store size: 00 sb, 01 sh, 10 sw.
REQ-008 mem_addr  in  32  effective address (alu_out); mem_wr_data  in  32  store data (rs2).
REQ-009 finish_2  out  1  one-cycle completion pulse; mem_rd_data  out  32  load result; mem_err  out  1  sticky-per-op error flag; busy  out  1.
REQ-010 AXI4-Lite master: araddr 32, arvalid, arready, rdata 32, rresp 2, rvalid, rready, awaddr 32, awvalid, awready, wdata 32, wstrb 4, wvalid, wready, bresp 2, bvalid, bready.

Function
REQ-011 States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
REQ-012 IDLE + valid_2 + mem_rd_en only -> RD_ADDR; mem_wr_en only -> WR_REQ; neither -> DONE (no bus traffic); both -> DONE with mem_err=1.
REQ-013 Request fields (ctrl, address, store data) latched at acceptance; inputs ignored while busy.
REQ-014 Misalignment (half at odd address, word at address[1:0]!=0) -> DONE with mem_err=1, no bus transaction.
REQ-015 araddr/awaddr = latched address with [1:0] cleared.
REQ-016 RD_ADDR: arvalid=1 held until arready; same-cycle handshake -> RD_DATA.
REQ-017 RD_DATA: rready=1; on rvalid capture rdata, select byte/half by address[1:0], sign- or zero-extend per ctrl -> DONE; rresp!=00 sets mem_err.
REQ-018 WR_REQ: awvalid and wvalid raised together; each dropped independently after its handshake; -> WR_RESP in the cycle both are complete (same-cycle or staggered).
REQ-019 wdata = store data replicated into lanes (sb: byte x4, sh: half x2, sw: as-is); wstrb = 0001<<addr[1:0] (sb), 0011<<addr[1:0] (sh), 1111 (sw).
REQ-020 WR_RESP: bready=1; on bvalid -> DONE; bresp!=00 sets mem_err.
REQ-021 DONE: finish_2=1 for exactly one cycle, then IDLE; mem_rd_data and mem_err hold until next acceptance.
REQ-022 busy=1 in every state except IDLE; valid_2 during busy is dropped, not queued.
REQ-023 AXI valid outputs never depend combinationally on ready inputs; once raised, a valid stays high until its handshake.
REQ-024 Minimum latency: load 3 cycles valid_2 -> finish_2 (ready/valid asserted at first opportunity); store 3 cycles; no-op or error 1 cycle.

Reset
REQ-025 rst low asynchronously forces IDLE; all valids, readies, finish_2, busy, mem_err = 0; mem_rd_data = 0.
REQ-026 Reset mid-transaction abandons the transaction with no finish_2; after release, the first valid_2 is accepted normally.

Verification
REQ-027 lbu at 0x8000_0003, rdata=0x80AB_CDEF, arready/rvalid immediate -> araddr 0x8000_0000, mem_rd_data 0x0000_0080, finish_2 3 cycles after valid_2.
REQ-028 lh at 0x8000_0002, rdata=0x8001_1234 -> mem_rd_data 0xFFFF_8001, mem_err=0.
REQ-029 sh at 0x8000_0002, data 0x1234_5678, awready 2 cycles after wready -> wdata 0x5678_5678, wstrb 1100, awvalid held until accepted, single finish_2 after bvalid.
REQ-030 lw at 0x8000_0001 -> no arvalid, finish_2 next cycle, mem_err=1.
REQ-031 sw with bresp=10 -> finish_2, mem_err=1; following lw with rresp=00 clears mem_err.
REQ-032 rst low while in RD_DATA -> arvalid/rready drop at once, no finish_2; next lw after release completes normally.
